// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time integer clock divider; ratio/start/stop changes land on period boundaries.
// Optional DIVCTRL_ODD50_EN adds a negedge copy of div_out for exact 50% duty on odd ratios.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cur_n, pend_div, pend_n;
  logic div_q, div_n, tick_n, err_n, xfer, take, wrap;
  assign cfg_ready = state != PEND;
  assign busy      = state != IDLE;
  assign xfer      = cfg_valid && cfg_ready;
  assign take      = xfer && (cfg_div >= CNT_W'(2));
  assign wrap      = cnt == cur_div - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= CNT_W'(DEFAULT_DIV);
      div_q    <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_div  <= cur_n;
      pend_div <= pend_n;
      div_q    <= div_n;
      tick     <= tick_n;
      cfg_err  <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur_div;
    pend_n  = pend_div;
    div_n   = 1'b0;
    tick_n  = 1'b0;
    err_n   = xfer && !take;
    if (state == IDLE) begin
      if (take) cur_n = cfg_div;
      if (en) begin
        state_n = RUN;
        cnt_n   = '0;
        div_n   = 1'b1;
        tick_n  = 1'b1;
      end
    end else if (!wrap) begin
      cnt_n = cnt + 1'b1;
      div_n = cnt_n < (cur_div >> 1);
      if (take) begin
        state_n = PEND;
        pend_n  = cfg_div;
      end
    end else begin
      if (state == PEND) cur_n = pend_div;
      cnt_n = '0;
      // a ratio accepted on the wrap edge waits for the next wrap, unless we stop here
      if (!en) begin
        state_n = IDLE;
        if (take) cur_n = cfg_div;
      end else begin
        state_n = take ? PEND : RUN;
        div_n   = 1'b1;
        tick_n  = 1'b1;
        if (take) pend_n = cfg_div;
      end
    end
  end
`ifdef DIVCTRL_ODD50_EN
  logic neg_q;
  always_ff @(negedge clk or negedge rst)
    if (!rst) neg_q <= 1'b0;
    else neg_q <= div_q;
  assign div_out = div_q | (cur_div[0] & neg_q);
`else
  assign div_out = div_q;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: vector table, hand-written corner sequences, and random traffic against a period-level model.
module tb_clk_div_ctrl;
  logic clk, rst, en, cfg_valid, cfg_ready, cfg_err, div_out, tick, busy;
  logic [7:0] cfg_div, cur_div;
  int checks = 0, errors = 0;

  typedef struct {
    bit en, v;
    logic [7:0] d;
    bit xd, xt, xr, xb, xe;
    logic [7:0] xc;
  } vec_t;
  vec_t tab[40];

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_out(div_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t row(int e, int v, int d, int xd, int xt, int xr, int xb, int xe, int xc);
    vec_t r;
    r.en = e[0]; r.v = v[0]; r.d = d[7:0];
    r.xd = xd[0]; r.xt = xt[0]; r.xr = xr[0]; r.xb = xb[0]; r.xe = xe[0]; r.xc = xc[7:0];
    return r;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input bit xd, xt, xr, xb, xe, input logic [7:0] xc);
    cmp("div_out", int'(div_out), int'(xd));
    cmp("tick", int'(tick), int'(xt));
    cmp("cfg_ready", int'(cfg_ready), int'(xr));
    cmp("busy", int'(busy), int'(xb));
    cmp("cfg_err", int'(cfg_err), int'(xe));
    cmp("cur_div", int'(cur_div), int'(xc));
  endtask

  // called at a negedge: drive, clock once, check just after the edge, return at the next negedge
  task automatic vec(input bit e, v, input logic [7:0] d, input bit xd, xt, xr, xb, xe, input logic [7:0] xc);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    #1 check_all(xd, xt, xr, xb, xe, xc);
    @(negedge clk);
  endtask

  // period-level reference: running flag, position in period, ratio, optional queued ratio
  bit m_run, m_pend, m_err;
  int m_pos, m_n, m_pn;

  task automatic model_edge(input bit e, v, input int d);
    bit x, ok;
    x = v && !m_pend;
    ok = x && d >= 2;
    m_err = x && !ok;
    if (!m_run) begin
      if (ok) m_n = d;
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (m_pos < m_n - 1) begin
      m_pos++;
      if (ok) begin m_pend = 1; m_pn = d; end
    end else begin
      if (m_pend) m_n = m_pn;
      m_pend = 0;
      if (ok) begin m_pend = 1; m_pn = d; end
      m_pos = 0;
      if (!e) begin
        m_run = 0;
        if (m_pend) m_n = m_pn;
        m_pend = 0;
      end
    end
  endtask

  initial begin
    rst = 0; en = 0; cfg_valid = 0; cfg_div = 0;
    tab[0]  = row(1,0,0, 1,1,1,1,0,3);
    tab[1]  = row(1,0,0, 0,0,1,1,0,3);
    tab[2]  = row(1,0,0, 0,0,1,1,0,3);
    tab[3]  = row(1,0,0, 1,1,1,1,0,3);
    tab[4]  = row(1,1,4, 0,0,0,1,0,3);
    tab[5]  = row(1,1,5, 0,0,0,1,0,3);
    tab[6]  = row(1,1,5, 1,1,1,1,0,4);
    tab[7]  = row(1,1,5, 1,0,0,1,0,4);
    tab[8]  = row(1,0,0, 0,0,0,1,0,4);
    tab[9]  = row(1,0,0, 0,0,0,1,0,4);
    tab[10] = row(1,0,0, 1,1,1,1,0,5);
    tab[11] = row(1,0,0, 1,0,1,1,0,5);
    tab[12] = row(1,0,0, 0,0,1,1,0,5);
    tab[13] = row(1,0,0, 0,0,1,1,0,5);
    tab[14] = row(1,0,0, 0,0,1,1,0,5);
    tab[15] = row(1,0,0, 1,1,1,1,0,5);
    tab[16] = row(1,1,1, 1,0,1,1,1,5);
    tab[17] = row(1,0,0, 0,0,1,1,0,5);
    tab[18] = row(1,0,0, 0,0,1,1,0,5);
    tab[19] = row(1,0,0, 0,0,1,1,0,5);
    tab[20] = row(1,0,0, 1,1,1,1,0,5);
    tab[21] = row(1,1,6, 1,0,0,1,0,5);
    tab[22] = row(1,0,0, 0,0,0,1,0,5);
    tab[23] = row(1,0,0, 0,0,0,1,0,5);
    tab[24] = row(1,0,0, 0,0,0,1,0,5);
    tab[25] = row(1,0,0, 1,1,1,1,0,6);
    tab[26] = row(0,0,0, 1,0,1,1,0,6);
    tab[27] = row(0,0,0, 1,0,1,1,0,6);
    tab[28] = row(0,0,0, 0,0,1,1,0,6);
    tab[29] = row(0,0,0, 0,0,1,1,0,6);
    tab[30] = row(0,0,0, 0,0,1,1,0,6);
    tab[31] = row(0,0,0, 0,0,1,0,0,6);
    tab[32] = row(0,0,0, 0,0,1,0,0,6);
    tab[33] = row(1,0,0, 1,1,1,1,0,6);
    tab[34] = row(1,0,0, 1,0,1,1,0,6);
    tab[35] = row(0,0,0, 1,0,1,1,0,6);
    tab[36] = row(0,0,0, 0,0,1,1,0,6);
    tab[37] = row(1,0,0, 0,0,1,1,0,6);
    tab[38] = row(1,0,0, 0,0,1,1,0,6);
    tab[39] = row(1,0,0, 1,1,1,1,0,6);

    #12 check_all(0, 0, 1, 0, 0, 3);
    #5 rst = 1;
    @(negedge clk);
    for (int i = 0; i < 40; i++)
      vec(tab[i].en, tab[i].v, tab[i].d, tab[i].xd, tab[i].xt, tab[i].xr, tab[i].xb, tab[i].xe, tab[i].xc);

    // async reset mid-period with a ratio pending
    vec(1, 1, 4, 1, 0, 0, 1, 0, 6);
    #2 rst = 0;
    #1 check_all(0, 0, 1, 0, 0, 3);
    @(negedge clk);
    rst = 1;
    vec(1, 0, 0, 1, 1, 1, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 1, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 1, 1, 0, 3);
    vec(1, 0, 0, 1, 1, 1, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 1, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 1, 1, 0, 3);
    // transfer on the wrap edge applies one wrap later
    vec(1, 1, 2, 1, 1, 0, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 0, 1, 0, 3);
    vec(1, 0, 0, 0, 0, 0, 1, 0, 3);
    vec(1, 0, 0, 1, 1, 1, 1, 0, 2);
    // stop at a wrap with a pending ratio: applied, then idle
    vec(1, 1, 5, 0, 0, 0, 1, 0, 2);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 5);
    vec(1, 0, 0, 1, 1, 1, 1, 0, 5);

    // random traffic against the model
    rst = 0;
    @(negedge clk);
    rst = 1;
    m_run = 0; m_pend = 0; m_err = 0; m_pos = 0; m_n = 3; m_pn = 3;
    for (int i = 0; i < 400; i++) begin
      bit e, v;
      int d;
      e = $urandom_range(0, 9) != 0;
      v = $urandom_range(0, 2) == 0;
      d = $urandom_range(0, 9);
      model_edge(e, v, d);
      vec(e, v, d[7:0], m_run && m_pos < m_n / 2, m_run && m_pos == 0, !m_pend, m_run, m_err, m_n[7:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
